fire2_squeeze_collector: RTL and testbench

- Downstream neighbour of the fire2 squeeze 3x3 stage.
- Accepts one DSP_NO-wide vector of post-ReLU squeeze outputs per output pixel.
- Serialises each vector into a channel-major activation RAM.
- Exposes a 1-cycle-latency read port to the fire2 expand stages.
- Signals layer completion once all H_OUT*W_OUT pixels are stored.

---
 rtl/fire2_pkg.sv | 18 +
 rtl/fire2_act_ram.sv | 28 ++
 rtl/fire2_squeeze_collector.sv | 167 ++++++++++++++++
 tb/tb_fire2_squeeze_collector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire2_pkg.sv
// Shared constants and types for the fire2 squeeze collector and its activation RAM.
package fire2_pkg;

  localparam int DSP_NO = 16;
  localparam int WIDTH  = 16;
  localparam int H_OUT  = 64;
  localparam int W_OUT  = 64;

  typedef logic [WIDTH-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } collector_state_t;

endpackage

// File: rtl/fire2_act_ram.sv
// Simple dual-port activation RAM: one synchronous write port, one registered read port.
module fire2_act_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Separate read process: a same-address read during a write returns the old word.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fire2_squeeze_collector.sv
// Serialises DSP_NO-wide squeeze vectors into a channel-major activation RAM.
// Optional shadow capture register enabled by FIRE2_SQUEEZE_COLLECTOR_DBUF_EN.
module fire2_squeeze_collector
  import fire2_pkg::*;
#(
  parameter int  H_OUT  = fire2_pkg::H_OUT,
  parameter int  W_OUT  = fire2_pkg::W_OUT,
  localparam int PIXELS = H_OUT * W_OUT,
  localparam int DEPTH  = DSP_NO * PIXELS,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  act_t             ofm [0:DSP_NO-1],
  input  logic [ADDR_W-1:0] rd_addr,
  output act_t             rd_data,
  output logic             busy,
  output logic             layer_end,
  output logic             overflow,
  output collector_state_t state,
  output logic [PIX_W-1:0] pix_cnt
);

  localparam int CH_W = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  // in_valid is a valid-only strobe with no ready: a vector is taken on the edge
  // where it is high and the collector can hold it, otherwise it is dropped.
  collector_state_t state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             ovf_q, ovf_d;
  act_t             cap_q [DSP_NO];
  logic             cap_ld_in;
  logic             we;
  logic [ADDR_W-1:0] wr_addr;
  act_t             wr_data;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
  act_t             sh_q [DSP_NO];
  logic             sh_full_q, sh_ld, sh_clr, cap_ld_sh;
`endif

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    ch_d      = ch_q;
    ovf_d     = ovf_q;
    cap_ld_in = 1'b0;
    we        = 1'b0;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
    sh_ld     = 1'b0;
    sh_clr    = 1'b0;
    cap_ld_sh = 1'b0;
`endif
    if (start) begin
      state_d = COLLECT;
      pix_d   = '0;
      ch_d    = '0;
      ovf_d   = 1'b0;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
      sh_clr  = 1'b1;
`endif
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_valid) begin
            cap_ld_in = 1'b1;
            ch_d      = '0;
            state_d   = DRAIN;
          end
        end
        DRAIN: begin
          we = 1'b1;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
          if (in_valid) begin
            if (sh_full_q) ovf_d = 1'b1;
            else           sh_ld = 1'b1;
          end
`else
          if (in_valid) ovf_d = 1'b1;
`endif
          if (ch_q == CH_W'(DSP_NO - 1)) begin
            ch_d = '0;
            if (pix_q == PIX_W'(PIXELS - 1)) begin
              state_d = DONE;
            end else begin
              pix_d   = pix_q + PIX_W'(1);
              state_d = COLLECT;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
              // Chain straight into the next drain from the shadow, or from a
              // vector arriving on the final write cycle.
              if (sh_full_q) begin
                cap_ld_sh = 1'b1;
                sh_clr    = 1'b1;
                state_d   = DRAIN;
              end else if (in_valid) begin
                cap_ld_in = 1'b1;
                sh_ld     = 1'b0;
                state_d   = DRAIN;
              end
`endif
            end
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      ch_q      <= '0;
      ovf_q     <= 1'b0;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
      sh_full_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      ch_q      <= ch_d;
      ovf_q     <= ovf_d;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
      if (sh_clr)     sh_full_q <= 1'b0;
      else if (sh_ld) sh_full_q <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (cap_ld_in) cap_q <= ofm;
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
    else if (cap_ld_sh) cap_q <= sh_q;
    if (sh_ld) sh_q <= ofm;
`endif
  end

  // Channel-major layout: all pixels of channel 0, then channel 1, and so on.
  assign wr_addr = ADDR_W'(ch_q) * ADDR_W'(PIXELS) + ADDR_W'(pix_q);
  assign wr_data = cap_q[ch_q];

  fire2_act_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy      = (state_q == COLLECT) || (state_q == DRAIN);
  assign layer_end = (state_q == DONE);
  assign overflow  = ovf_q;
  assign state     = state_q;
  assign pix_cnt   = pix_q;

endmodule

// File: tb/tb_fire2_squeeze_collector.sv
// Self-checking bench for fire2_squeeze_collector against a transaction-level RAM model.
module tb_fire2_squeeze_collector;
  import fire2_pkg::*;

  localparam int H     = 8;
  localparam int W     = 16;
  localparam int PIX   = H * W;
  localparam int DEPTH = DSP_NO * PIX;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(PIX);

  logic             clk = 1'b0;
  logic             rst, start, in_valid;
  act_t             ofm [0:DSP_NO-1];
  logic [AW-1:0]    rd_addr;
  act_t             rd_data;
  logic             busy, layer_end, overflow;
  collector_state_t state;
  logic [PW-1:0]    pix_cnt;

  int vectors = 0;
  int miscompares = 0;

  act_t             ref_mem [DEPTH];
  bit               ref_known [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  fire2_squeeze_collector #(.H_OUT(H), .W_OUT(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .ofm       (ofm),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .layer_end (layer_end),
    .overflow  (overflow),
    .state     (state),
    .pix_cnt   (pix_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_vec();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < DSP_NO; i++) ofm[i] = act_t'($urandom);
  endtask

  // Model: an accepted vector lands channel-major at pixel p.
  task automatic store_vec(input int p);
    for (int i = 0; i < DSP_NO; i++) begin
      ref_mem[i*PIX + p]   = ofm[i];
      ref_known[i*PIX + p] = 1'b1;
    end
  endtask

  task automatic read_word(input int a, output act_t d);
    rd_addr = AW'(a);
    tick();
    d = rd_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; rd_addr = '0;
    for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
    idle(3);
    rst = 1'b0;
    vectors++; if (state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
    vectors++; if (pix_cnt !== '0) begin miscompares++; $display("FAIL reset_pix: got %0d expected 0", pix_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (layer_end !== 1'b0) begin miscompares++; $display("FAIL reset_layer_end: got %b expected 0", layer_end); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    for (int i = 0; i < DSP_NO; i++) ofm[i] = act_t'(i + 1);
    drive_vec();
    idle(2);
    vectors++; if (state !== IDLE) begin miscompares++; $display("FAIL idle_valid_state: got %0d expected %0d", state, IDLE); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL idle_valid_overflow: got %b expected 0", overflow); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_valid_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    act_t d;
    pulse_start();
    vectors++; if (state !== COLLECT) begin miscompares++; $display("FAIL single_armed: got %0d expected %0d", state, COLLECT); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    for (int i = 0; i < DSP_NO; i++) ofm[i] = act_t'(16'h0100 * (i + 1));
    drive_vec();
    store_vec(0);
    vectors++; if (state !== DRAIN) begin miscompares++; $display("FAIL single_drain: got %0d expected %0d", state, DRAIN); end
    idle(DSP_NO - 1);
    vectors++; if (state !== DRAIN) begin miscompares++; $display("FAIL single_drain_len: got %0d expected %0d", state, DRAIN); end
    idle(1);
    vectors++; if (state !== COLLECT) begin miscompares++; $display("FAIL single_back: got %0d expected %0d", state, COLLECT); end
    vectors++; if (pix_cnt !== PW'(1)) begin miscompares++; $display("FAIL single_pix: got %0d expected 1", pix_cnt); end
    rd_addr = '0;
    tick();
    rd_addr = AW'(PIX);
    #1;
    vectors++; if (rd_data !== 16'h0100) begin miscompares++; $display("FAIL rd_latency_hold: got %h expected 0100", rd_data); end
    tick();
    vectors++; if (rd_data !== 16'h0200) begin miscompares++; $display("FAIL rd_ch1_pix0: got %h expected 0200", rd_data); end
    for (int i = 0; i < DSP_NO; i++) begin
      read_word(i*PIX, d);
      vectors++; if (d !== ref_mem[i*PIX]) begin miscompares++; $display("FAIL single_readback ch%0d: got %h expected %h", i, d, ref_mem[i*PIX]); end
    end
  endtask

  task automatic test_drain_collision();
    act_t d;
    pulse_start();
    rand_vec();
    drive_vec();
    store_vec(0);
    idle(4);
    rand_vec();
    drive_vec();
`ifdef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
    store_vec(1);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL dbuf_shadow_ovf: got %b expected 0", overflow); end
    rand_vec();
    idle(2);
    drive_vec();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL dbuf_full_ovf: got %b expected 1", overflow); end
    idle(8);
    vectors++; if (state !== DRAIN) begin miscompares++; $display("FAIL dbuf_chain_state: got %0d expected %0d", state, DRAIN); end
    vectors++; if (pix_cnt !== PW'(1)) begin miscompares++; $display("FAIL dbuf_chain_pix: got %0d expected 1", pix_cnt); end
    idle(DSP_NO);
    vectors++; if (state !== COLLECT) begin miscompares++; $display("FAIL dbuf_end_state: got %0d expected %0d", state, COLLECT); end
    vectors++; if (pix_cnt !== PW'(2)) begin miscompares++; $display("FAIL dbuf_end_pix: got %0d expected 2", pix_cnt); end
    for (int i = 0; i < DSP_NO; i++) begin
      read_word(i*PIX + 1, d);
      vectors++; if (d !== ref_mem[i*PIX + 1]) begin miscompares++; $display("FAIL dbuf_pix1 ch%0d: got %h expected %h", i, d, ref_mem[i*PIX + 1]); end
    end
`else
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL drop_ovf: got %b expected 1", overflow); end
    idle(11);
    vectors++; if (state !== COLLECT) begin miscompares++; $display("FAIL drop_state: got %0d expected %0d", state, COLLECT); end
    vectors++; if (pix_cnt !== PW'(1)) begin miscompares++; $display("FAIL drop_pix: got %0d expected 1", pix_cnt); end
`endif
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    for (int i = 0; i < DSP_NO; i++) begin
      read_word(i*PIX, d);
      vectors++; if (d !== ref_mem[i*PIX]) begin miscompares++; $display("FAIL collide_pix0 ch%0d: got %h expected %h", i, d, ref_mem[i*PIX]); end
    end
  endtask

  task automatic test_start_abort();
    act_t d;
    act_t c_vec [DSP_NO];
    pulse_start();
    rand_vec();
    for (int i = 0; i < DSP_NO; i++) c_vec[i] = ofm[i];
    drive_vec();
    idle(2);
    drive_vec();
    idle(4);
`ifndef FIRE2_SQUEEZE_COLLECTOR_DBUF_EN
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL abort_pre_ovf: got %b expected 1", overflow); end
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    // Channels 0..6 were written before the abort; the rest of pixel 0 is stale.
    for (int i = 0; i < DSP_NO; i++) begin
      ref_mem[i*PIX]   = c_vec[i];
      ref_known[i*PIX] = (i < 7);
    end
    vectors++; if (state !== COLLECT) begin miscompares++; $display("FAIL abort_state: got %0d expected %0d", state, COLLECT); end
    vectors++; if (pix_cnt !== '0) begin miscompares++; $display("FAIL abort_pix: got %0d expected 0", pix_cnt); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL abort_ovf: got %b expected 0", overflow); end
    for (int i = 0; i < 7; i++) begin
      read_word(i*PIX, d);
      vectors++; if (d !== ref_mem[i*PIX]) begin miscompares++; $display("FAIL abort_partial ch%0d: got %h expected %h", i, d, ref_mem[i*PIX]); end
    end
    vectors++; if (state !== COLLECT) begin miscompares++; $display("FAIL abort_no_resume: got %0d expected %0d", state, COLLECT); end
    rand_vec();
    drive_vec();
    store_vec(0);
    idle(DSP_NO);
    vectors++; if (pix_cnt !== PW'(1)) begin miscompares++; $display("FAIL abort_next_pix: got %0d expected 1", pix_cnt); end
    for (int i = 0; i < DSP_NO; i++) begin
      read_word(i*PIX, d);
      vectors++; if (d !== ref_mem[i*PIX]) begin miscompares++; $display("FAIL abort_next ch%0d: got %h expected %h", i, d, ref_mem[i*PIX]); end
    end
  endtask

  task automatic test_full_layer();
    act_t d, e;
    logic [WIDTH-1:0] mask;
    mask = WIDTH'($urandom);
    pulse_start();
    for (int k = 0; k < PIX; k++) begin
      for (int i = 0; i < DSP_NO; i++) ofm[i] = act_t'(WIDTH'(k ^ i) ^ mask);
      drive_vec();
      store_vec(k);
      if (k < PIX - 1) begin
        idle($urandom_range(17, 24) - 1);
        vectors++; if (pix_cnt !== PW'(k + 1)) begin miscompares++; $display("FAIL layer_pix k%0d: got %0d expected %0d", k, pix_cnt, k + 1); end
      end
    end
    idle(DSP_NO - 1);
    vectors++; if (layer_end !== 1'b0) begin miscompares++; $display("FAIL layer_end_early: got %b expected 0", layer_end); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL layer_busy_last: got %b expected 1", busy); end
    tick();
    vectors++; if (layer_end !== 1'b1) begin miscompares++; $display("FAIL layer_end_rise: got %b expected 1", layer_end); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL layer_busy_done: got %b expected 0", busy); end
    vectors++; if (state !== DONE) begin miscompares++; $display("FAIL layer_state: got %0d expected %0d", state, DONE); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL layer_ovf: got %b expected 0", overflow); end
    rand_vec();
    drive_vec();
    idle(1);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL done_valid_ovf: got %b expected 0", overflow); end
    vectors++; if (layer_end !== 1'b1) begin miscompares++; $display("FAIL done_hold: got %b expected 1", layer_end); end
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back(ref_mem[a]);
      read_word(a, d);
      e = exp_q.pop_front();
      vectors++; if (d !== e) begin miscompares++; $display("FAIL layer_readback addr%0d: got %h expected %h", a, d, e); end
    end
  endtask

  task automatic test_reset_in_done();
    act_t d;
    int a;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (layer_end !== 1'b0) begin miscompares++; $display("FAIL rst_done_layer_end: got %b expected 0", layer_end); end
    vectors++; if (state !== IDLE) begin miscompares++; $display("FAIL rst_done_state: got %0d expected %0d", state, IDLE); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_done_busy: got %b expected 0", busy); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL rst_done_rd_data: got %h expected 0", rd_data); end
    for (int n = 0; n < 64; n++) begin
      a = $urandom_range(0, DEPTH - 1);
      if (ref_known[a]) begin
        read_word(a, d);
        vectors++; if (d !== ref_mem[a]) begin miscompares++; $display("FAIL rst_keep addr%0d: got %h expected %h", a, d, ref_mem[a]); end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int a = 0; a < DEPTH; a++) ref_known[a] = 1'b0;
    test_reset();
    test_single();
    test_drain_collision();
    test_start_abort();
    test_full_layer();
    test_reset_in_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
